// File: rtl/fb_frame_draw_ctrl_if.sv
// Sample-source handshake and framebuffer write port for the frame draw controller.
// The controller is the master: it requests samples and drives pixel writes.
interface fb_frame_draw_ctrl_if;
    logic       sample_req;
    logic [9:0] sample_idx;
    logic       sample_valid;
    logic [8:0] sample_y;
    logic [9:0] x;
    logic [8:0] y;
    logic       pixel_color;
    logic       pixel_write;

    modport master (
        output sample_req, sample_idx, x, y, pixel_color, pixel_write,
        input  sample_valid, sample_y
    );

    modport slave (
        input  sample_req, sample_idx, x, y, pixel_color, pixel_write,
        output sample_valid, sample_y
    );
endinterface

// File: rtl/fb_frame_draw_ctrl.sv
// Per-frame sequencer: clears the back buffer, fetches one sample per column,
// then plots the waveform as vertical segments joining adjacent samples.
module fb_frame_draw_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_frame_start,
    fb_frame_draw_ctrl_if.master        draw_bus,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic                        o_frame_drop
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    logic [2:0] r_state;
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic [8:0] r_ye;
    logic [8:0] r_prev;
    logic [9:0] r_idx;
    logic       r_color;
    logic       r_write;
    logic       r_req;
    logic       r_busy;
    logic       r_done;
    logic       r_drop;

    logic [8:0] w_cur;
    logic [8:0] w_prev;
    logic [8:0] w_ys;
    logic [8:0] w_ye;

    // The first column has no predecessor, so its segment collapses to one pixel.
    always_comb begin
        w_cur  = (draw_bus.sample_y > Y_LAST) ? Y_LAST : draw_bus.sample_y;
        w_prev = (r_idx == 10'd0) ? w_cur : r_prev;
        w_ys   = (w_prev < w_cur) ? w_prev : w_cur;
        w_ye   = (w_prev < w_cur) ? w_cur : w_prev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_ye    <= '0;
            r_prev  <= '0;
            r_idx   <= '0;
            r_color <= 1'b0;
            r_write <= 1'b0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= i_frame_start && (r_state != S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_state <= S_CLEAR;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_color <= 1'b0;
                        r_write <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_x == X_LAST && r_y == Y_LAST) begin
                        r_state <= S_FETCH;
                        r_write <= 1'b0;
                        r_req   <= 1'b1;
                        r_idx   <= '0;
                    end else if (r_x == X_LAST) begin
                        r_x <= '0;
                        r_y <= r_y + 9'd1;
                    end else begin
                        r_x <= r_x + 10'd1;
                    end
                end
                // The sample is consumed here, so it becomes the predecessor right away.
                S_FETCH: begin
                    if (draw_bus.sample_valid) begin
                        r_state <= S_DRAW;
                        r_req   <= 1'b0;
                        r_write <= 1'b1;
                        r_color <= 1'b1;
                        r_x     <= r_idx;
                        r_y     <= w_ys;
                        r_ye    <= w_ye;
                        r_prev  <= w_cur;
                    end
                end
                S_DRAW: begin
                    if (r_y == r_ye) begin
                        r_write <= 1'b0;
                        if (r_idx == X_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_idx   <= r_idx + 10'd1;
                            r_req   <= 1'b1;
                        end
                    end else begin
                        r_y <= r_y + 9'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_write <= 1'b0;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign draw_bus.sample_req  = r_req;
    assign draw_bus.sample_idx  = r_idx;
    assign draw_bus.x           = r_x;
    assign draw_bus.y           = r_y;
    assign draw_bus.pixel_color = r_color;
    assign draw_bus.pixel_write = r_write;
    assign o_busy               = r_busy;
    assign o_frame_done         = r_done;
    assign o_frame_drop         = r_drop;
endmodule

// File: tb/tb_fb_frame_draw_ctrl.sv
// Scoreboard bench for fb_frame_draw_ctrl on a reduced screen size; a behavioural
// frame model queues expected writes and a negedge monitor checks every write.
module tb_fb_frame_draw_ctrl;
    localparam int W = 40;
    localparam int H = 30;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       c;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frameStart = 1'b0;
    logic busy;
    logic frameDone;
    logic frameDrop;

    logic [8:0] sampleMem [0:1023];
    int srcMode = 0;
    int stallCnt = 0;
    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;
    int doneCount = 0;
    int dropCount = 0;
    int startCyc = 0;
    wr_t expQ[$];
    wr_t monExp;
    logic prevReq = 1'b0;
    logic prevValid = 1'b0;
    logic [9:0] prevIdx = '0;
    logic rstSeen = 1'b1;

    fb_frame_draw_ctrl_if bus();

    fb_frame_draw_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_start(frameStart),
        .draw_bus     (bus),
        .o_busy       (busy),
        .o_frame_done (frameDone),
        .o_frame_drop (frameDrop)
    );

    assign bus.sample_y = sampleMem[bus.sample_idx];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle++;
        rstSeen = rst;
    end

    // Sample source: never valid, always valid, or valid on the sixth request cycle.
    always @(posedge clk) begin
        #1;
        case (srcMode)
            1: begin
                stallCnt = 0;
                bus.sample_valid = 1'b1;
            end
            2: begin
                if (bus.sample_req) begin
                    stallCnt++;
                    bus.sample_valid = (stallCnt > 5);
                end else begin
                    stallCnt = 0;
                    bus.sample_valid = 1'b0;
                end
            end
            default: begin
                stallCnt = 0;
                bus.sample_valid = 1'b0;
            end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every write, plus request stability while stalled.
    always @(negedge clk) begin
        if (bus.pixel_write === 1'b1) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL pixel: got write (%0d,%0d) color %0d, expected no write",
                         bus.x, bus.y, bus.pixel_color);
            end else begin
                monExp = expQ.pop_front();
                if (bus.x !== monExp.x || bus.y !== monExp.y || bus.pixel_color !== monExp.c) begin
                    testsFailed++;
                    $display("[TB] FAIL pixel: got (%0d,%0d) color %0d, expected (%0d,%0d) color %0d",
                             bus.x, bus.y, bus.pixel_color, monExp.x, monExp.y, monExp.c);
                end
            end
        end
        if (prevReq === 1'b1 && prevValid !== 1'b1 && !rstSeen) begin
            testsRun++;
            if (bus.sample_req !== 1'b1 || bus.sample_idx !== prevIdx) begin
                testsFailed++;
                $display("[TB] FAIL stall hold: got req %0d idx %0d, expected req 1 idx %0d",
                         bus.sample_req, bus.sample_idx, prevIdx);
            end
        end
        if (bus.sample_req === 1'b1) begin
            testsRun++;
            if (bus.pixel_write !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL fetch write: got pixel_write %0d, expected 0", bus.pixel_write);
            end
        end
        if (frameDone === 1'b1) doneCount++;
        if (frameDrop === 1'b1) dropCount++;
        prevReq   = bus.sample_req;
        prevValid = bus.sample_valid;
        prevIdx   = bus.sample_idx;
    end

    function automatic void pushW(input int xx, input int yy, input logic c);
        wr_t w;
        w.x = 10'(xx);
        w.y = 9'(yy);
        w.c = c;
        expQ.push_back(w);
    endfunction

    // Reference frame: returns cycles from first clear write to frame_done with a zero-wait source.
    function automatic int modelFrame(input bit clearOnly);
        int cost;
        int prevY;
        int cur;
        int lo;
        int hi;
        cost  = W * H;
        prevY = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                pushW(xx, yy, 1'b0);
        if (!clearOnly) begin
            for (int c = 0; c < W; c++) begin
                cur = (int'(sampleMem[c]) >= H) ? H - 1 : int'(sampleMem[c]);
                if (c == 0) prevY = cur;
                lo = (prevY < cur) ? prevY : cur;
                hi = (prevY < cur) ? cur : prevY;
                for (int r = lo; r <= hi; r++) pushW(c, r, 1'b1);
                cost += 1 + (hi - lo + 1);
                prevY = cur;
            end
        end
        return cost;
    endfunction

    task automatic applyStimulus(input bit expectStart);
        frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
        if (expectStart) begin
            checkOutput("start write", 32'(bus.pixel_write), 32'd1);
            checkOutput("start x", 32'(bus.x), 32'd0);
            checkOutput("start y", 32'(bus.y), 32'd0);
            checkOutput("start busy", 32'(busy), 32'd1);
            startCyc = cycle;
        end else begin
            checkOutput("drop pulse", 32'(frameDrop), 32'd1);
        end
    endtask

    task automatic waitDone(input int budget, output int doneCyc);
        int n;
        n = 0;
        while (frameDone !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done seen", 32'(frameDone), 32'd1);
        doneCyc = (frameDone === 1'b1) ? cycle : -1;
    endtask

    task automatic runFrame(input string name, input int extraPerCol);
        int cost;
        int doneCyc;
        int baseDone;
        baseDone = doneCount;
        cost = modelFrame(1'b0);
        applyStimulus(1'b1);
        waitDone(20000, doneCyc);
        checkOutput({name, " frame time"}, 32'(doneCyc - startCyc), 32'(cost + extraPerCol * W));
        @(posedge clk); #1;
        checkOutput({name, " busy low"}, 32'(busy), 32'd0);
        checkOutput({name, " queue empty"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, " done count"}, 32'(doneCount - baseDone), 32'd1);
    endtask

    function automatic void randomSamples();
        for (int i = 0; i < 1024; i++) sampleMem[i] = 9'($urandom_range(0, 511));
    endfunction

    initial begin
        int found;
        int baseDone;
        int baseDrop;
        int doneCyc;
        int cost;
        for (int i = 0; i < 1024; i++) sampleMem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset write", 32'(bus.pixel_write), 32'd0);
        checkOutput("reset req", 32'(bus.sample_req), 32'd0);
        checkOutput("reset idx", 32'(bus.sample_idx), 32'd0);
        checkOutput("reset x", 32'(bus.x), 32'd0);
        checkOutput("reset y", 32'(bus.y), 32'd0);
        checkOutput("reset color", 32'(bus.pixel_color), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(frameDone), 32'd0);
        checkOutput("reset drop", 32'(frameDrop), 32'd0);
        rst = 1'b0;

        // Clear sweep with the sample source silent, then a held request.
        srcMode = 0;
        void'(modelFrame(1'b1));
        applyStimulus(1'b1);
        repeat (W * H) begin
            @(posedge clk); #1;
        end
        checkOutput("clear queue empty", 32'(expQ.size()), 32'd0);
        checkOutput("fetch req", 32'(bus.sample_req), 32'd1);
        checkOutput("fetch idx", 32'(bus.sample_idx), 32'd0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("fetch req held", 32'(bus.sample_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("sweep reset busy", 32'(busy), 32'd0);

        srcMode = 1;
        for (int i = 0; i < 1024; i++) sampleMem[i] = 9'(H / 2);
        runFrame("flat", 0);

        randomSamples();
        sampleMem[0] = 9'd10;
        sampleMem[1] = 9'd15;
        sampleMem[2] = 9'd511;
        runFrame("ramp", 0);

        srcMode = 2;
        runFrame("stall", 5);

        // Overlapping frame_start pulses: one during the clear, one in the DONE cycle.
        srcMode = 1;
        randomSamples();
        baseDone = doneCount;
        baseDrop = dropCount;
        cost = modelFrame(1'b0);
        applyStimulus(1'b1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        applyStimulus(1'b0);
        waitDone(20000, doneCyc);
        checkOutput("overlap frame time", 32'(doneCyc - startCyc), 32'(cost));
        frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
        checkOutput("done-cycle drop", 32'(frameDrop), 32'd1);
        checkOutput("done-cycle busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("overlap idle write", 32'(bus.pixel_write), 32'd0);
        checkOutput("overlap drop count", 32'(dropCount - baseDrop), 32'd2);
        checkOutput("overlap done count", 32'(doneCount - baseDone), 32'd1);
        checkOutput("overlap queue empty", 32'(expQ.size()), 32'd0);

        // Reset while drawing column 20, then a clean restart.
        randomSamples();
        void'(modelFrame(1'b0));
        applyStimulus(1'b1);
        found = 0;
        for (int n = 0; n < 20000 && found == 0; n++) begin
            if (bus.pixel_write === 1'b1 && bus.pixel_color === 1'b1 && bus.x == 10'd20) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkOutput("reached col 20", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        checkOutput("mid reset write", 32'(bus.pixel_write), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        randomSamples();
        runFrame("restart", 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/fb_frame_draw_ctrl.md
Name: fb_frame_draw_ctrl

Overview:
- Per-frame drawing sequencer for the monochrome double-buffered VGA framebuffer.
- On each frame_start pulse it does three things in order:
  - clears the back buffer;
  - fetches one audio sample per screen column from the sample source over a req/valid handshake;
  - plots a connected waveform as vertical line segments.
- Drives the framebuffer write port (x, y, pixel_color, pixel_write) and is its sole writer.

Parameters:
- WIDTH, 640, visible columns; x range 0..WIDTH-1.
- HEIGHT, 480, visible rows; y range 0..HEIGHT-1.

Ports:
- clk  in  1  system clock (same clock as framebuffer)
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse from framebuffer at buffer swap
- sample_req  out  1  request for sample at sample_idx
- sample_idx  out  10  column index of requested sample
- sample_valid  in  1  sample_y valid; completes handshake when sample_req=1
- sample_y  in  9  row for this column, already scaled; values >= HEIGHT are clamped to HEIGHT-1
- x  out  10  framebuffer write column
- y  out  9  framebuffer write row
- pixel_color  out  1  write data: 0 = black (clear), 1 = white (trace)
- pixel_write  out  1  framebuffer write enable
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when drawing completes
- frame_drop  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; x=0, y=0, pixel_color=0, pixel_write=0, sample_req=0, sample_idx=0, busy=0, frame_done=0, frame_drop=0.
- Reset mid-operation: the state returns to IDLE and pixel_write=0 from the next cycle. The partial frame is abandoned.
- FSM states and transitions:
  - IDLE: wait for frame_start. frame_start seen at cycle T gives the first clear write at T+1.
  - CLEAR: one write per cycle with pixel_color=0.
    - Raster order: x 0..WIDTH-1, then y++, starting at (0,0).
    - After the write at (WIDTH-1, HEIGHT-1), go to FETCH with col=0.
    - Exactly WIDTH*HEIGHT = 307200 writes.
  - FETCH: pixel_write=0; sample_req=1, sample_idx=col.
    - Hold until sample_valid=1. That cycle accepts; sample_req drops the next cycle.
    - cur = min(sample_y, HEIGHT-1).
    - If col==0, prev=cur.
    - Load the segment registers: ys = min(prev,cur), ye = max(prev,cur). Go to DRAW.
    - sample_valid while sample_req=0 is ignored.
  - DRAW: one write per cycle at (col, ys..ye) inclusive, pixel_color=1, ys incrementing.
    - Segment length is ye-ys+1 cycles, minimum 1.
    - After the write at ye: prev=cur. If col==WIDTH-1 go to DONE, else col++ and go to FETCH.
  - DONE: frame_done=1 for one cycle, then IDLE.
- Throughput: the total frame cost must be less than 1600*524 = 838400 clk cycles. With a zero-wait sample source:
  - worst case is 307200 + 640*(1+480) = 615040 cycles;
  - best case is 307200 + 1280 cycles.
- frame_start while busy: ignored for sequencing; frame_drop pulses the same cycle it is seen (registered, so visible at T+1). The current frame continues.
- frame_start in the same cycle as the DONE→IDLE transition: counts as busy, so it is dropped.
- Counter widths: x/col are 10 bits and y/ys/ye are 9 bits, with no wrap. Terminal compares use WIDTH-1 and HEIGHT-1.
- pixel_write is high only in CLEAR and DRAW. x and y are don't-care when pixel_write=0 but hold their last value.

Test Plan:
- Clear sweep: rst, then a frame_start pulse, sample_valid tied low.
  - Required: exactly 307200 writes with color 0.
  - First write at (0,0), last at (639,479), row-major, no gaps.
  - Then sample_req=1 with sample_idx=0, held.
- Flat trace: sample_valid always 1, sample_y=240.
  - Required: 640 writes with color 1 at (c,240) for c=0..639.
  - frame_done pulses once, 307200+1280 cycles after the first clear write.
  - busy then deasserts.
- Ramp and clamp: sample_y = 100, 105, 511 for columns 0, 1, 2.
  - Required: column 0 writes row 100 only.
  - Column 1 writes rows 100..105.
  - Column 2 writes rows 105..479 (clamped).
- Handshake stall: sample_valid delayed 5 cycles per request.
  - Required: sample_req and sample_idx stay stable during the stall.
  - No pixel_write while stalled.
  - Trace identical to the no-stall run.
- Overlapping frame_start: second pulse during CLEAR and a third in the DONE cycle.
  - Required: two frame_drop pulses.
  - The first frame completes unaffected with exactly one frame_done.
- Mid-frame reset: rst asserted during DRAW at col 300.
  - Required: pixel_write=0 and busy=0 the next cycle.
  - Next frame_start restarts the clear at (0,0).
